// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: command inputs and valid/ready serial output of the pattern generator
interface seq_pattern_gen_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeats;
  logic             abort;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             busy;
  logic             done;
  modport master (
    output start, pattern, repeats, abort, bit_ready,
    input  bit_out, bit_valid, busy, done
  );
  modport slave (
    input  start, pattern, repeats, abort, bit_ready,
    output bit_out, bit_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: sends a captured pattern MSB first, repeated a programmed number of times
module seq_pattern_gen #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               rst,
  seq_pattern_gen_if.slave  s
);
  localparam int IDX_W = PAT_W > 1 ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t           state, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             xfer;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat_q <= '0;
      rep_q <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      pat_q <= pat_d;
      rep_q <= rep_d;
      idx   <= idx_d;
    end
  end
  // Abort outranks everything outside IDLE; DONE and any illegal encoding fall back to IDLE.
  always_comb begin
    state_d = state;
    pat_d   = pat_q;
    rep_d   = rep_q;
    idx_d   = idx;
    xfer    = state == SEND && s.bit_ready;
    if (state == IDLE) begin
      if (s.start) begin
        pat_d   = s.pattern;
        rep_d   = s.repeats;
        idx_d   = IDX_LAST;
        state_d = s.repeats != '0 ? SEND : DONE;
      end
    end else if (s.abort || state != SEND) begin
      state_d = IDLE;
    end else if (xfer) begin
      if (idx != '0) begin
        idx_d = idx - IDX_W'(1);
      end else if (rep_q > CNT_W'(1)) begin
        rep_d = rep_q - CNT_W'(1);
        idx_d = IDX_LAST;
      end else begin
        state_d = DONE;
      end
    end
  end
  always_comb begin
    s.bit_valid = state == SEND;
    s.bit_out   = state == SEND ? pat_q[idx] : 1'b0;
    s.busy      = state == SEND || state == DONE;
    s.done      = state == DONE;
  end
endmodule
